top_proc: RTL and testbench
===========================

# top_proc

Multicycle RV32I-subset processor core that executes each instruction over five clock cycles: fetch, decode, execute, memory and write-back. It drives an external synchronous instruction ROM through `PC`/`instr` and an external synchronous data RAM through `dAddress`/`dWriteData`/`dReadData`/`MemRead`/`MemWrite`. It is the top of the processor hierarchy and contains the FSM, the 32x32 register file, the immediate generator, the ALU and the PC logic.

## Interface
- `INITIAL_PC`, 32'h0040_0000: PC value loaded at reset. Memories decode only `PC[8:0]` and `dAddress[8:0]`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous reset, active-low (already decided).
- `instr`  in  32: ROM data. Valid from the cycle after PC is presented and stable until PC changes.
- `PC`  out  32: current instruction address (the ROM address).
- `dAddress`  out  32: data address; equals the ALUOut register.
- `dWriteData`  out  32: store data; equals the latched rs2 register B.
- `dReadData`  in  32: RAM data. Valid the cycle after a MEM-state edge.
- `WriteBackData`  out  32: value written to rd.
- `MemRead`  out  1: high in MEM for LW.
- `MemWrite`  out  1: high in MEM for SW.

## Operation
- FSM states IF→ID→EX→MEM→WB→IF, one cycle each and unconditional. All instructions take 5 cycles, including those with no memory access.
- IF: `PC` is presented to the ROM.
- ID: decode directly from `instr`. Latch A=rs1 data, B=rs2 data and Imm. Register x0 reads 0.
- EX: ALUOut ← ALU(A, B or Imm).
- MEM: drive `MemRead` (LW) or `MemWrite` (SW).
- WB:
  - Write rd for R-type, I-ALU and LW. Writes to x0 are ignored.
  - On the WB→IF edge, PC ← PC+Imm for a BEQ that is taken (A==B); otherwise PC ← PC+4.
- Supported instructions:
  - LW, SW (address = rs1+imm).
  - BEQ (B-type immediate, byte offset).
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
- Arithmetic and width rules:
  - SLT/SLTI compare signed and return 0 or 1.
  - Shift amount is `[4:0]`; SRA/SRAI is arithmetic.
  - Immediates are sign-extended; arithmetic wraps modulo 2^32.
- Any other opcode or funct combination executes as a NOP: no register write, no memory strobe, PC+4.
- `WriteBackData` = `dReadData` when the state is WB and the opcode is LW; otherwise ALUOut.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - state=IF and PC=`INITIAL_PC`.
  - All 32 registers, A, B, Imm and ALUOut = 0.
  - Outputs: `MemRead`=`MemWrite`=0, `dAddress`=`dWriteData`=`WriteBackData`=0.
- First fetch occurs in the first cycle after `rst` rises.
- Reset asserted mid-instruction aborts it: no further register or memory write.
- `MemRead`/`MemWrite` are single-cycle pulses in MEM only; they are never high together.
- A store is committed by the RAM on the MEM→WB edge.
- Load data is sampled and written to rd on the WB→IF edge.
- PC changes only on the WB→IF edge. Throughput is 1 instruction per 5 clocks.
- A register written in WB is readable by the next instruction's ID.

## Configuration
- `TOP_PROC_SHIFT_EN` defined: SLL, SRL, SRA, SLLI, SRLI and SRAI are implemented.
- `TOP_PROC_SHIFT_EN` undefined: the ALU has no shifter, and those six instructions execute as NOPs (no rd write, PC+4).

## Test plan
- Reset then release:
  - PC=`INITIAL_PC` during reset and through the first 5 cycles.
  - PC=`INITIAL_PC`+4 after the 5th rising edge.
  - `MemRead`=`MemWrite`=0 throughout.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2; SLT x5,x2,x1 → WB values 5, 0xFFFFFFFD, 2, 8, 1.
- SW x1,8(x0) then LW x6,8(x0):
  - `MemWrite` pulses in the store's MEM state with `dAddress`=8 and `dWriteData`=5.
  - The load's WB shows `WriteBackData`=5.
- BEQ x1,x1,+12 → PC advances by 12. BEQ x1,x2,+12 → PC advances by 4.
- SRAI x7,x2,1 → 0xFFFFFFFE with `TOP_PROC_SHIFT_EN`; no write (x7 stays 0) without it.
- Run 128 instructions of a loaded program over 12800 time units; then assert `rst` mid-EX → PC=`INITIAL_PC` immediately and no write occurs.

Source files
------------

// File: rtl/top_proc.sv
// top_proc: five-state multicycle RV32I-subset core (IF, ID, EX, MEM, WB).
// Define TOP_PROC_SHIFT_EN to build the shifter and the six shift instructions.
module top_proc #(
  parameter logic [31:0] INITIAL_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic [31:0] dAddress,
  output logic [31:0] dWriteData,
  input  logic [31:0] dReadData,
  output logic [31:0] WriteBackData,
  output logic        MemRead,
  output logic        MemWrite
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLT, OP_SLL, OP_SRL, OP_SRA
  } alu_op_t;

  state_t      state, state_nx;
  alu_op_t     op;
  logic [31:0] regs [32];
  logic [31:0] a, b, imm, alu_out;
  logic [31:0] imm_d, opnd, alu_y, pc_nx;
  logic [31:0] i_imm, s_imm, b_imm;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        use_imm, rd_we;
  logic        is_lw, is_sw, is_beq, is_r, is_i;

  // Instruction stays valid on the ROM port until PC changes, so decode is live.
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};

  assign is_lw  = (opcode == 7'h03) && (f3 == 3'b010);
  assign is_sw  = (opcode == 7'h23) && (f3 == 3'b010);
  assign is_beq = (opcode == 7'h63) && (f3 == 3'b000);
  assign is_r   = (opcode == 7'h33);
  assign is_i   = (opcode == 7'h13);

  always_comb begin
    op      = OP_ADD;
    use_imm = 1'b0;
    rd_we   = 1'b0;
    imm_d   = '0;
    unique case (1'b1)
      is_lw: begin
        use_imm = 1'b1;
        rd_we   = 1'b1;
        imm_d   = i_imm;
      end
      is_sw: begin
        use_imm = 1'b1;
        imm_d   = s_imm;
      end
      is_beq: begin
        op    = OP_SUB;
        imm_d = b_imm;
      end
      is_r: begin
        rd_we = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: op = OP_ADD;
          {7'h20, 3'b000}: op = OP_SUB;
          {7'h00, 3'b111}: op = OP_AND;
          {7'h00, 3'b110}: op = OP_OR;
          {7'h00, 3'b100}: op = OP_XOR;
          {7'h00, 3'b010}: op = OP_SLT;
`ifdef TOP_PROC_SHIFT_EN
          {7'h00, 3'b001}: op = OP_SLL;
          {7'h00, 3'b101}: op = OP_SRL;
          {7'h20, 3'b101}: op = OP_SRA;
`endif
          default: rd_we = 1'b0;
        endcase
      end
      is_i: begin
        use_imm = 1'b1;
        rd_we   = 1'b1;
        imm_d   = i_imm;
        case (f3)
          3'b000: op = OP_ADD;
          3'b111: op = OP_AND;
          3'b110: op = OP_OR;
          3'b100: op = OP_XOR;
          3'b010: op = OP_SLT;
`ifdef TOP_PROC_SHIFT_EN
          3'b001: begin
            if (f7 == 7'h00) op = OP_SLL;
            else rd_we = 1'b0;
          end
          3'b101: begin
            if (f7 == 7'h00) op = OP_SRL;
            else if (f7 == 7'h20) op = OP_SRA;
            else rd_we = 1'b0;
          end
`endif
          default: rd_we = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign opnd = use_imm ? imm : b;

  always_comb begin
    alu_y = a + opnd;
    case (op)
      OP_SUB: alu_y = a - opnd;
      OP_AND: alu_y = a & opnd;
      OP_OR:  alu_y = a | opnd;
      OP_XOR: alu_y = a ^ opnd;
      OP_SLT: alu_y = {31'b0, $signed(a) < $signed(opnd)};
`ifdef TOP_PROC_SHIFT_EN
      OP_SLL: alu_y = a << opnd[4:0];
      OP_SRL: alu_y = a >> opnd[4:0];
      OP_SRA: alu_y = $signed(a) >>> opnd[4:0];
`endif
      default: alu_y = a + opnd;
    endcase
  end

  assign pc_nx = (is_beq && (a == b)) ? PC + imm : PC + 32'd4;

  always_comb begin
    state_nx      = S_IF;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    WriteBackData = alu_out;
    unique case (state)
      S_IF: state_nx = S_ID;
      S_ID: state_nx = S_EX;
      S_EX: state_nx = S_MEM;
      S_MEM: begin
        state_nx = S_WB;
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB: begin
        state_nx = S_IF;
        if (is_lw) WriteBackData = dReadData;
      end
      default: state_nx = S_IF;
    endcase
  end

  assign dAddress   = alu_out;
  assign dWriteData = b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IF;
      PC      <= INITIAL_PC;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_ID: begin
          a   <= (rs1 == 5'd0) ? '0 : regs[rs1];
          b   <= (rs2 == 5'd0) ? '0 : regs[rs2];
          imm <= imm_d;
        end
        S_EX: alu_out <= alu_y;
        S_WB: begin
          if (rd_we && (rd != 5'd0)) regs[rd] <= WriteBackData;
          PC <= pc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_proc.sv
// tb_top_proc: scoreboard bench for top_proc with behavioural ROM and RAM.
// Build with TOP_PROC_SHIFT_EN to match a shifter-enabled core.
module tb_top_proc;

  localparam logic [31:0] INIT = 32'h0040_0000;
`ifdef TOP_PROC_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        chk;
    logic [31:0] wb;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst;
  logic [31:0] instr, PC, dAddress, dWriteData, dReadData, WriteBackData;
  logic        MemRead, MemWrite;

  logic [31:0] rom [128];
  logic [31:0] ram [128];
  logic [31:0] prog [32];
  exp_t        tbl [32];
  int          nxt [32];
  exp_t        exp_q [$];
  exp_t        cur;
  bit          have, mon_en;
  int          cyc, ph, n_cmp, n_bad;

  top_proc #(.INITIAL_PC(INIT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .PC(PC),
    .dAddress(dAddress), .dWriteData(dWriteData),
    .dReadData(dReadData), .WriteBackData(WriteBackData),
    .MemRead(MemRead), .MemWrite(MemWrite)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    instr <= rom[PC[8:2]];
    if (MemWrite) ram[dAddress[8:2]] <= dWriteData;
    dReadData <= ram[dAddress[8:2]];
  end

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {im, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [11:0] im,
      input logic [4:0] rs1, input logic [4:0] rd);
    return {im, rs1, 3'b010, rd, 7'h03};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] im,
      input logic [4:0] rs2, input logic [4:0] rs1);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [12:0] im,
      input logic [4:0] rs2, input logic [4:0] rs1);
    return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'h63};
  endfunction

  task automatic put(input int i, input logic [31:0] ins,
                     input logic c, input logic [31:0] v);
    prog[i]    = ins;
    tbl[i].chk = c;
    tbl[i].wb  = v;
  endtask

  task automatic put_mem(input int i, input logic r, input logic w,
                         input logic [31:0] ad, input logic [31:0] dt);
    tbl[i].rd   = r;
    tbl[i].wr   = w;
    tbl[i].addr = ad;
    tbl[i].data = dt;
  endtask

  task automatic push(input int i);
    exp_t e;
    e    = tbl[i];
    e.pc = INIT + 32'(i * 4);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst && mon_en) begin
      ph = cyc % 5;
      if (ph == 0) begin
        if (exp_q.size() == 0) begin
          have = 1'b0;
          n_cmp++;
          n_bad++;
          $display("FAIL underflow: got empty queue expected entry");
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          check("if_pc", PC, cur.pc);
        end
      end
      if (ph != 3) check("idle_strobe", {30'b0, MemRead, MemWrite}, 32'd0);
      if (have && ph == 3) begin
        check("mem_strobe", {30'b0, MemRead, MemWrite},
              {30'b0, cur.rd, cur.wr});
        if (cur.rd || cur.wr) check("mem_addr", dAddress, cur.addr);
        if (cur.wr) check("mem_data", dWriteData, cur.data);
      end
      if (have && ph == 4) begin
        check("wb_pc", PC, cur.pc);
        if (cur.chk) check("wb_data", WriteBackData, cur.wb);
      end
    end
  end

  initial begin
    int idx;
    rst    = 1'b0;
    mon_en = 1'b0;
    have   = 1'b0;
    n_cmp  = 0;
    n_bad  = 0;
    for (int i = 0; i < 128; i++) begin
      rom[i] = 32'h0000_0013;
      ram[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      tbl[i] = '0;
      nxt[i] = i + 1;
    end
    put(0,  enc_i(12'd5, 0, 3'b000, 1), 1, 32'd5);
    put(1,  enc_i(12'hFFD, 0, 3'b000, 2), 1, 32'hFFFF_FFFD);
    put(2,  enc_r(7'h00, 2, 1, 3'b000, 3), 1, 32'd2);
    put(3,  enc_r(7'h20, 2, 1, 3'b000, 4), 1, 32'd8);
    put(4,  enc_r(7'h00, 1, 2, 3'b010, 5), 1, 32'd1);
    put(5,  enc_sw(12'd8, 1, 0), 0, 0);
    put_mem(5, 0, 1, 32'd8, 32'd5);
    put(6,  enc_lw(12'd8, 0, 6), 1, 32'd5);
    put_mem(6, 1, 0, 32'd8, 0);
    put(7,  enc_beq(13'd12, 1, 1), 0, 0);
    nxt[7] = 10;
    put(8,  enc_i(12'd99, 0, 3'b000, 7), 0, 0);
    put(9,  enc_i(12'd99, 0, 3'b000, 7), 0, 0);
    put(10, enc_beq(13'd12, 2, 1), 0, 0);
    put(11, enc_i(12'h401, 2, 3'b101, 7), SH, 32'hFFFF_FFFE);
    put(12, enc_r(7'h00, 0, 7, 3'b000, 8), 1,
        SH ? 32'hFFFF_FFFE : 32'd0);
    put(13, enc_r(7'h00, 2, 1, 3'b100, 9), 1, 32'hFFFF_FFF8);
    put(14, enc_r(7'h00, 2, 1, 3'b110, 10), 1, 32'hFFFF_FFFD);
    put(15, enc_r(7'h00, 2, 1, 3'b111, 11), 1, 32'd5);
    put(16, enc_i(12'h0F0, 2, 3'b111, 12), 1, 32'h0000_00F0);
    put(17, enc_i(12'hFF0, 1, 3'b110, 13), 1, 32'hFFFF_FFF5);
    put(18, enc_i(12'hFFF, 1, 3'b100, 14), 1, 32'hFFFF_FFFA);
    put(19, enc_i(12'hFFE, 2, 3'b010, 15), 1, 32'd1);
    put(20, enc_r(7'h00, 2, 1, 3'b010, 16), 1, 32'd0);
    put(21, enc_i(12'd7, 0, 3'b000, 0), 1, 32'd7);
    put(22, enc_r(7'h00, 1, 0, 3'b000, 17), 1, 32'd5);
    put(23, 32'hFFFF_FFFF, 0, 0);
    put(24, enc_i(12'd1, 0, 3'b011, 18), 0, 0);
    put(25, enc_r(7'h00, 0, 18, 3'b000, 19), 1, 32'd0);
    put(26, enc_i(12'd3, 1, 3'b001, 20), SH, 32'h0000_0028);
    put(27, enc_r(7'h00, 0, 20, 3'b000, 22), 1,
        SH ? 32'h0000_0028 : 32'd0);
    put(28, enc_r(7'h00, 1, 2, 3'b101, 21), SH, 32'h07FF_FFFF);
    put(29, enc_sw(12'd16, 9, 0), 0, 0);
    put_mem(29, 0, 1, 32'd16, 32'hFFFF_FFF8);
    put(30, enc_lw(12'd16, 0, 23), 1, 32'hFFFF_FFF8);
    put_mem(30, 1, 0, 32'd16, 0);
    put(31, enc_beq(13'h1F84, 0, 0), 0, 0);
    nxt[31] = 0;
    for (int i = 0; i < 32; i++) rom[i] = prog[i];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", PC, INIT);
    check("rst_strobe", {30'b0, MemRead, MemWrite}, 32'd0);
    check("rst_daddr", dAddress, 32'd0);
    check("rst_wdata", dWriteData, 32'd0);
    check("rst_wb", WriteBackData, 32'd0);

    idx = 0;
    for (int n = 0; n < 128; n++) begin
      push(idx);
      idx = nxt[idx];
    end
    mon_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (640) @(posedge clk);
    mon_en = 1'b0;
    check("drain_run", exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    #5 rst = 1'b0;
    #1;
    check("abort_pc", PC, INIT);
    check("abort_strobe", {30'b0, MemRead, MemWrite}, 32'd0);
    check("abort_wb", WriteBackData, 32'd0);
    check("abort_daddr", dAddress, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold", {30'b0, MemRead, MemWrite}, 32'd0);
    end

    push(0);
    push(1);
    mon_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    mon_en = 1'b0;
    check("drain_restart", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
